stream_demux_1_to_4: RTL and testbench

- Registered 1-to-4 demultiplexer with valid/ready handshake.
- Routes one input word stream to one of four output channels, chosen per word by a 2-bit select.
- Sits at the ALU result/operand distribution point: the inverse of the 4-to-1 selection path.
- Each channel owns a one-entry holding register, so a stalled channel never blocks words bound for the other channels.

---
 rtl/stream_demux_1_to_4.sv | 147 ++++++++++++++
 tb/tb_stream_demux_1_to_4.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_to_4.sv
// -----------------------------------------------------------------------------
// stream_demux_1_to_4
//
// Registered 1-to-4 stream demultiplexer with a valid/ready handshake. Each
// input word goes to the output channel picked by in_select. Every channel has
// its own one-entry holding slot, so a stalled channel does not block words
// bound for the other channels. A slot that drains and reloads in the same
// cycle stays full, which gives one word per cycle per channel.
//
// Optional feature (compile-time macro DEMUX_BROADCAST_EN):
//   When defined, in_broadcast = 1 loads the word into all four slots. The
//   word is accepted only when all four slots are free. When not defined,
//   in_broadcast is ignored.
//
// Ports:
//   clk           single clock, rising-edge state updates
//   rst           asynchronous, active-high reset
//   in_valid      input word present
//   in_ready      the slot addressed by in_select (or every slot, for a
//                 broadcast) is free this cycle
//   in_data       input word
//   in_select     target channel 0..3
//   in_broadcast  broadcast request (only used with DEMUX_BROADCAST_EN)
//   out_valid     bit i: channel i slot holds a word
//   out_ready     bit i: downstream of channel i takes the word
//   out_data      channel i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   accept_count  number of accepted input words, modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module stream_demux_1_to_4 #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_select,
    input  logic                    in_broadcast,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]    accept_count
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e           state_q [4];
    slot_state_e           state_d [4];
    logic [DATA_WIDTH-1:0] data_q  [4];
    logic [DATA_WIDTH-1:0] data_d  [4];
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;

    logic [3:0] slot_free;
    logic [3:0] load_mask;
    logic       bcast_sel;
    logic       accept;

`ifdef DEMUX_BROADCAST_EN
    assign bcast_sel = in_broadcast;
`else
    // The port stays on the interface so both builds share one pinout.
    logic unused_broadcast;
    assign unused_broadcast = in_broadcast;
    assign bcast_sel        = 1'b0;
`endif

    // A slot is free when it is empty or when its word leaves this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        slot_free = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            slot_free[i] = (state_q[i] == SLOT_EMPTY) || out_ready[i];
        end
    end

    // in_ready deliberately ignores in_valid so upstream may look at it first.
    assign in_ready = bcast_sel ? (&slot_free) : slot_free[in_select];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load_mask = 4'b0000;
        if (accept) begin
            if (bcast_sel) begin
                load_mask = 4'b1111;
            end else begin
                load_mask[in_select] = 1'b1;
            end
        end
    end

    // Per-slot EMPTY/FULL next state. A load takes priority over a drain, so
    // drain+reload keeps the slot full with the new word.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            if (load_mask[i]) begin
                state_d[i] = SLOT_FULL;
                data_d[i]  = in_data;
            end else if ((state_q[i] == SLOT_FULL) && out_ready[i]) begin
                // Data is left as is: out_data keeps its last word after a drain.
                state_d[i] = SLOT_EMPTY;
            end
        end
        count_d = count_q + CNT_WIDTH'(accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data slots are reset too, not just the valid bits,
            // because out_data must read zero after reset.
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= SLOT_EMPTY;
                data_q[i]  <= '0;
            end
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values.
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        out_valid = 4'b0000;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]                          = (state_q[i] == SLOT_FULL);
            out_data[i*DATA_WIDTH +: DATA_WIDTH]  = data_q[i];
        end
    end

    assign accept_count = count_q;

endmodule

// File: tb/tb_stream_demux_1_to_4.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1_to_4
//
// Directed bench for stream_demux_1_to_4. The stimulus tasks push the expected
// word into a per-channel queue when a word is accepted. A separate monitor
// pops from that queue and compares whenever a channel hands a word
// downstream. Inputs change 1 ns after the rising edge, and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_stream_demux_1_to_4;

    localparam int DW = 8;
    localparam int CW = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_select;
    logic            in_broadcast;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic [CW-1:0]   accept_count;

    stream_demux_1_to_4 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_select    (in_select),
        .in_broadcast (in_broadcast),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .accept_count (accept_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cyc          = 0;
    logic [DW-1:0] exp_q [4][$];
    logic [CW-1:0] exp_count;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake seen at the falling edge completes on
    // the next rising edge.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_word_ch%0d", i), 64'(out_data[i*DW +: DW]), 64'hdead);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("data_ch%0d", i), 64'(out_data[i*DW +: DW]), 64'(e));
                    end
                end
            end
        end
    end

    // Call 1 ns after a rising edge. Returns 1 ns after the accepting edge.
    task automatic send(input logic [1:0] sel, input logic [DW-1:0] d, input logic bc, output int waits);
        waits        = 0;
        in_valid     = 1'b1;
        in_data      = d;
        in_select    = sel;
        in_broadcast = bc;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'h1);
            @(posedge clk);
            #1;
        end else begin
`ifdef DEMUX_BROADCAST_EN
            if (bc) begin
                for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
            end else begin
                exp_q[sel].push_back(d);
            end
`else
            exp_q[sel].push_back(d);
`endif
            exp_count++;
            @(posedge clk);
            #1;
        end
        in_valid     = 1'b0;
        in_broadcast = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int c0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_select    = 2'd0;
        in_broadcast = 1'b0;
        out_ready    = 4'b1111;
        exp_count    = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_count", 64'(accept_count), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        do_reset();

        // Idle after reset: every channel is ready.
        for (int s = 0; s < 4; s++) begin
            in_select = 2'(s);
            #1;
            check($sformatf("idle_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end
        check("idle_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;

        // Sequential routing: each channel pulses for exactly one cycle.
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 8'hA0 + 8'(i), 1'b0, w);
            check($sformatf("seq_waits_%0d", i), 64'(w), 64'h0);
            check($sformatf("seq_out_valid_%0d", i), 64'(out_valid), 64'(4'b0001 << i));
        end
        check("seq_count", 64'(accept_count), 64'd4);
        @(posedge clk);
        #1;
        check("seq_drained", 64'(out_valid), 64'h0);

        // Back-pressure on channel 2.
        out_ready = 4'b1011;
        send(2'd2, 8'h11, 1'b0, w);
        check("bp_hold_valid", 64'(out_valid), 64'b0100);
        in_valid  = 1'b1;
        in_data   = 8'h22;
        in_select = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_blocked", 64'(in_ready), 64'h0);
            check("bp_slot_stable", 64'(out_data[2*DW +: DW]), 64'h11);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(2'd0, 8'h33, 1'b0, w);
        check("bp_other_ch_waits", 64'(w), 64'h0);
        check("bp_other_ch_valid", 64'(out_valid), 64'b0101);
        out_ready = 4'b1111;
        send(2'd2, 8'h22, 1'b0, w);
        check("bp_reload_waits", 64'(w), 64'h0);
        check("bp_reload_valid2", 64'(out_valid[2]), 64'h1);
        check("bp_reload_data2", 64'(out_data[2*DW +: DW]), 64'h22);
        check("bp_count", 64'(accept_count), 64'(exp_count));
        @(posedge clk);
        #1;

        // Throughput: ten back-to-back words to channel 1.
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            send(2'd1, 8'h40 + 8'(i), 1'b0, w);
            check($sformatf("tput_waits_%0d", i), 64'(w), 64'h0);
            check($sformatf("tput_valid_%0d", i), 64'(out_valid[1]), 64'h1);
        end
        check("tput_cycles", 64'(cyc - c0), 64'd10);
        check("tput_count", 64'(accept_count), 64'(exp_count));
        @(posedge clk);
        #1;

`ifdef DEMUX_BROADCAST_EN
        // Broadcast blocked by a stalled channel 1, then released.
        out_ready = 4'b1101;
        send(2'd1, 8'h77, 1'b0, w);
        in_valid     = 1'b1;
        in_data      = 8'h5A;
        in_select    = 2'd0;
        in_broadcast = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bc_blocked", 64'(in_ready), 64'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        @(negedge clk);
        check("bc_ready", 64'(in_ready), 64'h1);
        for (int i = 0; i < 4; i++) exp_q[i].push_back(8'h5A);
        exp_count++;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_broadcast = 1'b0;
        check("bc_out_valid", 64'(out_valid), 64'hF);
        check("bc_out_data", 64'(out_data), 64'h5A5A_5A5A);
        check("bc_count", 64'(accept_count), 64'(exp_count));
`else
        // Without the feature, in_broadcast must not change routing.
        send(2'd2, 8'h5A, 1'b1, w);
        check("nobc_out_valid", 64'(out_valid), 64'b0100);
        check("nobc_count", 64'(accept_count), 64'(exp_count));
`endif
        @(posedge clk);
        #1;

        // Counter wrap: 256 accepts from reset.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(2'(i % 4), 8'(i), 1'b0, w);
        end
        check("wrap_count", 64'(accept_count), 64'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset with slot 3 full and stalled.
        out_ready = 4'b0111;
        send(2'd3, 8'hC3, 1'b0, w);
        check("ar_slot3_full", 64'(out_valid), 64'b1000);
        check("ar_count_pre", 64'(accept_count), 64'h1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'h0);
        check("ar_count", 64'(accept_count), 64'h0);
        check("ar_out_data", 64'(out_data), 64'h0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        exp_count = '0;
        out_ready = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(2'd0, 8'hE0, 1'b0, w);
        check("ar_first_accept_waits", 64'(w), 64'h0);
        check("ar_first_accept_valid", 64'(out_valid), 64'b0001);
        check("ar_first_accept_count", 64'(accept_count), 64'h1);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("queue_empty_ch%0d", i), 64'(exp_q[i].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
